// File: rtl/full_adder_1_pkg.sv
// full_adder_1_pkg
//   Shared definitions for the full_adder_1 slice.
//   - FA_DEFAULT_WIDTH : default operand width of full_adder_1.
//   - fa_bit_t         : result bundle of one 1-bit adder cell.
//   - fa_eval()        : reference equations for one 1-bit cell
//                        (sum, carry-out, bit generate, bit propagate).
package full_adder_1_pkg;

  localparam int unsigned FA_DEFAULT_WIDTH = 1;

  typedef struct packed {
    logic s;   // sum bit
    logic co;  // carry out
    logic g;   // bit generate  (a & b)
    logic p;   // bit propagate (a ^ b)
  } fa_bit_t;

  function automatic fa_bit_t fa_eval(input logic a, input logic b, input logic ci);
    fa_bit_t r;
    r.g  = a & b;
    r.p  = a ^ b;
    r.s  = r.p ^ ci;
    // Equivalent to the majority form (a&b)|(a&ci)|(b&ci) because g and p
    // are mutually exclusive.
    r.co = r.g | (r.p & ci);
    return r;
  endfunction

endpackage

// File: rtl/full_adder_1_fa_cell.sv
// fa_cell
//   Purely combinational 1-bit full-adder cell used as the ripple element.
//   Ports:
//     a, b : operand bits
//     ci   : carry in
//     s    : sum bit
//     co   : carry out
//     g    : bit generate  (a & b)
//     p    : bit propagate (a ^ b)
module fa_cell
  import full_adder_1_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co,
  output logic g,
  output logic p
);

  fa_bit_t cell_res;

  assign cell_res = fa_eval(a, b, ci);
  assign s        = cell_res.s;
  assign co       = cell_res.co;
  assign g        = cell_res.g;
  assign p        = cell_res.p;

endmodule

// File: rtl/full_adder_1.sv
// full_adder_1
//   WIDTH-bit ripple-carry adder built from fa_cell instances, with group
//   generate/propagate/overflow flags and a registered copy of the result.
//   Ports:
//     clk    : rising-edge clock, used only by sum_q/cout_q
//     rst    : synchronous active-high reset, clears only sum_q/cout_q
//     a, b   : WIDTH-bit operands
//     cin    : carry in
//     sum    : combinational sum  ({cout,sum} = a + b + cin)
//     cout   : combinational carry out
//     gen    : group generate (carry out that would occur with cin = 0)
//     prop   : group propagate (AND over a ^ b)
//     ovf    : signed overflow (carry into MSB XOR carry out)
//     sum_q  : sum registered on clk
//     cout_q : cout registered on clk
module full_adder_1
  import full_adder_1_pkg::*;
#(
  parameter int unsigned WIDTH = FA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             gen,
  output logic             prop,
  output logic             ovf,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q
);

  // carry[i] is the carry into bit i; carry[WIDTH] is the carry out.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] g_bit;
  logic [WIDTH-1:0] p_bit;
  // gen_acc[i] is the group generate of bits [i-1:0], i.e. the carry into
  // bit i assuming cin = 0. Kept separate from the ripple so gen never
  // depends on cin.
  logic [WIDTH:0]   gen_acc;

  assign carry[0]   = cin;
  assign gen_acc[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      fa_cell u_cell (
        .a  (a[gi]),
        .b  (b[gi]),
        .ci (carry[gi]),
        .s  (sum[gi]),
        .co (carry[gi+1]),
        .g  (g_bit[gi]),
        .p  (p_bit[gi])
      );

      assign gen_acc[gi+1] = g_bit[gi] | (p_bit[gi] & gen_acc[gi]);
    end
  endgenerate

  assign cout = carry[WIDTH];
  assign gen  = gen_acc[WIDTH];
  assign prop = &p_bit;
  assign ovf  = carry[WIDTH-1] ^ carry[WIDTH];

  // Output register stage: one cycle of latency, reset wins over capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum;
      cout_q <= cout;
    end
  end

endmodule

// File: tb/tb_full_adder_1.sv
// tb_full_adder_1
//   Scoreboard bench for full_adder_1 at WIDTH=1 and WIDTH=4. Expected
//   results are queued when stimulus is applied and checked when the DUT
//   output is due (after settling for combinational outputs, one rising
//   edge later for registered outputs).
module tb_full_adder_1;

  logic       clk;
  logic       rst;
  logic       a1, b1, cin1;
  logic       sum1, cout1, gen1, prop1, ovf1, sum_q1, cout_q1;
  logic [3:0] a4, b4;
  logic       cin4;
  logic [3:0] sum4, sum_q4;
  logic       cout4, gen4, prop4, ovf4, cout_q4;

  int total = 0;
  int bad   = 0;

  // sel: 0 = WIDTH1 comb (sum/cout only), 1 = WIDTH1 comb all flags,
  //      2 = WIDTH1 registered, 3 = WIDTH4 comb all flags, 4 = WIDTH4 registered
  typedef struct {
    string      tag;
    int         sel;
    logic [3:0] sum;
    logic       cout;
    logic       gen;
    logic       prop;
    logic       ovf;
  } exp_t;

  exp_t sb[$];

  full_adder_1 #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1),
    .sum(sum1), .cout(cout1), .gen(gen1), .prop(prop1), .ovf(ovf1),
    .sum_q(sum_q1), .cout_q(cout_q1)
  );

  full_adder_1 #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4),
    .sum(sum4), .cout(cout4), .gen(gen4), .prop(prop4), .ovf(ovf4),
    .sum_q(sum_q4), .cout_q(cout_q4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int sel, input logic [3:0] s,
                          input logic co, input logic g, input logic p, input logic v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.sum = s; e.cout = co; e.gen = g; e.prop = p; e.ovf = v;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      check_val("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    case (e.sel)
      0: begin
        check_val({e.tag, ".sum"},  {31'd0, sum1},  {31'd0, e.sum[0]});
        check_val({e.tag, ".cout"}, {31'd0, cout1}, {31'd0, e.cout});
      end
      1: begin
        check_val({e.tag, ".sum"},  {31'd0, sum1},  {31'd0, e.sum[0]});
        check_val({e.tag, ".cout"}, {31'd0, cout1}, {31'd0, e.cout});
        check_val({e.tag, ".gen"},  {31'd0, gen1},  {31'd0, e.gen});
        check_val({e.tag, ".prop"}, {31'd0, prop1}, {31'd0, e.prop});
        check_val({e.tag, ".ovf"},  {31'd0, ovf1},  {31'd0, e.ovf});
      end
      2: begin
        check_val({e.tag, ".sum_q"},  {31'd0, sum_q1},  {31'd0, e.sum[0]});
        check_val({e.tag, ".cout_q"}, {31'd0, cout_q1}, {31'd0, e.cout});
      end
      3: begin
        check_val({e.tag, ".sum"},  {28'd0, sum4},  {28'd0, e.sum});
        check_val({e.tag, ".cout"}, {31'd0, cout4}, {31'd0, e.cout});
        check_val({e.tag, ".gen"},  {31'd0, gen4},  {31'd0, e.gen});
        check_val({e.tag, ".prop"}, {31'd0, prop4}, {31'd0, e.prop});
        check_val({e.tag, ".ovf"},  {31'd0, ovf4},  {31'd0, e.ovf});
      end
      default: begin
        check_val({e.tag, ".sum_q"},  {28'd0, sum_q4},  {28'd0, e.sum});
        check_val({e.tag, ".cout_q"}, {31'd0, cout_q4}, {31'd0, e.cout});
      end
    endcase
    $display("txn %s sel=%0d sum1=%b cout1=%b sum4=%h cout4=%b", e.tag, e.sel, sum1, cout1, sum4, cout4);
  endtask

  // Independent WIDTH=4 model from integer arithmetic and sign rule.
  task automatic push_model4(input string tag, input logic [3:0] a, input logic [3:0] b, input logic c);
    logic [4:0] tot;
    logic [4:0] tot0;
    logic [3:0] x;
    logic       v;
    tot  = {1'b0, a} + {1'b0, b} + {4'd0, c};
    tot0 = {1'b0, a} + {1'b0, b};
    x    = a ^ b;
    v    = (a[3] == b[3]) && (tot[3] != a[3]);
    push_exp(tag, 3, tot[3:0], tot[4], tot0[4], &x, v);
  endtask

  logic [2:0] vec_in  [8];
  logic [1:0] vec_out [8];

  initial begin
    // (a,b,cin) -> (sum,cout)
    vec_in[0] = 3'b000; vec_out[0] = 2'b00;
    vec_in[1] = 3'b001; vec_out[1] = 2'b10;
    vec_in[2] = 3'b010; vec_out[2] = 2'b10;
    vec_in[3] = 3'b100; vec_out[3] = 2'b10;
    vec_in[4] = 3'b110; vec_out[4] = 2'b01;
    vec_in[5] = 3'b111; vec_out[5] = 2'b11;
    vec_in[6] = 3'b011; vec_out[6] = 2'b01;
    vec_in[7] = 3'b101; vec_out[7] = 2'b01;

    rst = 1'b1;
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;

    // Reset held for two edges with nonzero inputs: registers must stay 0.
    for (int i = 0; i < 2; i++) begin
      push_exp($sformatf("reset_hold%0d", i), 2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      pop_check();
    end

    // Release reset with 1+1+1: result appears exactly one edge later.
    @(negedge clk);
    rst = 1'b0;
    push_exp("pre_edge", 2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    pop_check();
    push_exp("latency1", 2, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    pop_check();

    // Directed table, 10 ns between vectors.
    for (int i = 0; i < 8; i++) begin
      {a1, b1, cin1} = vec_in[i];
      push_exp($sformatf("vec_%b", vec_in[i]), 0, {3'd0, vec_out[i][1]}, vec_out[i][0], 1'b0, 1'b0, 1'b0);
      #1;
      pop_check();
      #9;
    end

    // Exhaustive WIDTH=1 against the reference equations.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic       s, co;
      v = i[2:0];
      {a1, b1, cin1} = v;
      s  = v[2] ^ v[1] ^ v[0];
      co = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
      push_exp($sformatf("exh_%b", v), 1, {3'd0, s}, co, v[2] & v[1], v[2] ^ v[1], v[0] ^ co);
      #1;
      pop_check();
      #9;
    end

    // Reset mid-stream with 1+1+0.
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
    push_exp("mid_pre", 2, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    pop_check();
    @(negedge clk);
    rst = 1'b1;
    push_exp("mid_rst_comb", 0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    pop_check();
    push_exp("mid_rst_reg", 2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    pop_check();
    push_exp("mid_rst_comb2", 0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    pop_check();
    @(negedge clk);
    rst = 1'b0;
    push_exp("mid_resume", 2, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    pop_check();

    // WIDTH=4 boundary cases, with spelled-out expectations.
    @(negedge clk);
    a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
    push_exp("w4_ff1", 3, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0);
    #1; pop_check();
    push_exp("w4_ff1_reg", 4, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    pop_check();
    @(negedge clk);
    a4 = 4'h7; b4 = 4'h1; cin4 = 1'b0;
    push_exp("w4_ovf", 3, 4'h8, 1'b0, 1'b0, 1'b0, 1'b1);
    #1; pop_check();
    #9;
    a4 = 4'h5; b4 = 4'hA; cin4 = 1'b1;
    push_exp("w4_prop", 3, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    #1; pop_check();
    #9;

    // WIDTH=4 random vectors against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      a4   = 4'($urandom_range(0, 15));
      b4   = 4'($urandom_range(0, 15));
      cin4 = 1'($urandom_range(0, 1));
      push_model4($sformatf("w4_rnd%0d", i), a4, b4, cin4);
      #1; pop_check();
      #9;
    end

    if (sb.size() != 0) check_val("scoreboard_leftover", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/full_adder_1.md
Name: full_adder_1

Overview:
- Full adder: adds operands a, b and carry-in cin, producing sum and carry-out with zero latency (purely combinational path).
- Default WIDTH=1 gives the classic 1-bit full adder cell; wider instances ripple identical cells.
- Also provides a registered copy of the result plus group generate/propagate/overflow flags, so the block can be used as a leaf in carry-lookahead or pipelined adders.

Parameters:
- WIDTH, 1, operand width in bits (≥1).

Ports:
- clk  in  1  clock; rising-edge active; used only by the registered outputs.
- rst  in  1  synchronous, active-high reset; affects only the registered outputs.
- a  in  WIDTH  operand A (unsigned, or two's complement for ovf).
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- sum  out  WIDTH  combinational sum bits.
- cout  out  1  combinational carry-out.
- gen  out  1  group generate: carry-out that would occur with cin=0.
- prop  out  1  group propagate: AND over bits of (a XOR b).
- ovf  out  1  signed overflow: carry into MSB XOR cout.
- sum_q  out  WIDTH  sum registered on clk.
- cout_q  out  1  cout registered on clk.

Behaviour:
- Arithmetic: {cout, sum} = a + b + cin, computed at WIDTH+1 bits with no truncation of the carry.
  - For WIDTH=1: sum = a^b^cin; cout = (a&b)|(a&cin)|(b&cin).
- sum, cout, gen, prop and ovf are purely combinational.
  - Valid within the same delta after any input change.
  - Independent of clk and rst, and correct even when clk/rst are unconnected or X.
- Group flags:
  - cout = gen | (prop & cin).
  - For WIDTH=1: gen = a&b; prop = a^b; ovf = carry into MSB XOR cout, which evaluates to cin XOR cout.
- Wrap-around: all-ones + all-ones + 1 gives sum = all-ones and cout = 1. There is no saturation.
- Registered outputs:
  - On each rising clk: sum_q ← sum and cout_q ← cout, giving 1-cycle latency.
  - While rst=1 at a rising edge: sum_q = 0 and cout_q = 0.
  - rst takes priority over capture.
- Reset mid-operation: clears only sum_q and cout_q. Combinational outputs keep tracking the inputs throughout reset.
- The block holds no other state and has no handshake.

Decomposition:
- No shared package is required; WIDTH is the only constant.
- One sub-module is natural: fa_cell, the 1-bit combinational cell with inputs a, b, ci and outputs s, co, g, p.
- full_adder_1 instantiates WIDTH fa_cell instances in a ripple chain:
  - ci[0] = cin; ci[i+1] = co[i].
  - Derive gen/prop from the per-bit g/p prefix.
  - Add the output register stage.

Test Plan:
- WIDTH=1, clk/rst unconnected: apply in sequence (a,b,cin) = 000, 001, 010, 100, 110, 111 with 10 ns between vectors. Required (sum,cout) = 00, 10, 10, 10, 01, 11 respectively.
- WIDTH=1 exhaustive over all 8 input combinations -> sum/cout match the reference equations.
  - gen = a&b, prop = a^b.
  - (a,b,cin) = 011 -> sum=0, cout=1; 101 -> sum=0, cout=1.
- WIDTH=1 with clock running: hold rst=1 for 2 cycles -> sum_q=0, cout_q=0. Then release rst and drive a=1, b=1, cin=1 -> sum_q=1, cout_q=1 exactly one rising edge later.
- Reset mid-stream: drive rst=1 for one cycle while a=1, b=1, cin=0 -> sum_q and cout_q go to 0 on that edge, while combinational sum=0, cout=1 remain unchanged throughout.
- WIDTH=4 boundary cases:
  - a=4'hF, b=4'hF, cin=1 -> sum=4'hF, cout=1, gen=1, prop=0.
  - a=4'h7, b=4'h1, cin=0 -> sum=4'h8, cout=0, ovf=1.
  - a=4'h5, b=4'hA, cin=1 -> sum=4'h0, cout=1, prop=1, gen=0.
